// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared types and constants for the accumulator CPU control
//            sequencer. Holds the state encoding, the opcode map and the
//            ALU operation encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH0 = 4'd1,
    ST_FETCH1 = 4'd2,
    ST_FETCH2 = 4'd3,
    ST_DECODE = 4'd4,
    ST_EX_RD  = 4'd5,
    ST_EX_ALU = 4'd6,
    ST_EX_ST0 = 4'd7,
    ST_EX_ST1 = 4'd8,
    ST_EX_JMP = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  // Opcode map (MBR[15:8])
  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h09;
  localparam logic [7:0] OP_OR     = 8'h0A;

  // ALU operation encodings
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // ALU operation selected by a memory-operand arithmetic/logic opcode
  function automatic logic [2:0] alu_op_for(input logic [7:0] op);
    logic [2:0] r;
    r = ALU_PASS;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

  // True for every opcode the sequencer knows how to execute
  function automatic logic is_legal(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_JMPGEZ,
      OP_JMP, OP_HALT, OP_AND, OP_OR: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
// ============================================================================
// Module   : cpu_ctrl_seq
// Purpose  : Hardwired fetch/decode/execute sequencer for the accumulator
//            CPU. Drives one strobe per datapath transfer from the current
//            state (and latched opcode for ALU select / illegal flag).
// Options  : CTRL_MEM_WAIT_EN - adds mem_ready; memory states stall until
//            the memory reports completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OPW-1:0]  mbr_opcode,
  input  logic            acc_neg,
`ifdef CTRL_MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            c_pc_to_mar,
  output logic            c_mbr_to_mar,
  output logic            c_mem_rd,
  output logic            c_mem_wr,
  output logic            c_pc_inc,
  output logic            c_pc_load,
  output logic            c_acc_to_mbr,
  output logic            c_acc_load,
  output logic [2:0]      c_alu_op,
  output logic            halted,
  output logic            illegal_op,
  output logic [CNTW-1:0] instr_cnt
);

  state_t         state;
  logic [OPW-1:0] opcode_q;
  logic [7:0]     op8;
  logic           mem_done;
  state_t         after_retire;

  assign op8 = 8'(opcode_q);

`ifdef CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // A finished instruction goes straight to the next fetch unless run dropped
  assign after_retire = run ? ST_FETCH0 : ST_IDLE;

  // State sequencing, opcode latch and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      opcode_q  <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_FETCH0;
        ST_FETCH0: state <= ST_FETCH1;
        ST_FETCH1: if (mem_done) state <= ST_FETCH2;
        ST_FETCH2: begin
          opcode_q <= mbr_opcode;
          state    <= ST_DECODE;
        end
        ST_DECODE: begin
          case (op8)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state <= ST_EX_RD;
            OP_STORE: state <= ST_EX_ST0;
            OP_JMP:   state <= ST_EX_JMP;
            OP_JMPGEZ: begin
              if (!acc_neg) begin
                state <= ST_EX_JMP;
              end else begin
                instr_cnt <= instr_cnt + 1'b1;
                state     <= after_retire;
              end
            end
            OP_HALT: begin
              // HALT retires on entry; the counter never moves again
              instr_cnt <= instr_cnt + 1'b1;
              state     <= ST_HALT;
            end
            default: begin
              // Undefined opcodes behave as a NOP
              instr_cnt <= instr_cnt + 1'b1;
              state     <= after_retire;
            end
          endcase
        end
        ST_EX_RD:  if (mem_done) state <= ST_EX_ALU;
        ST_EX_ALU: begin
          instr_cnt <= instr_cnt + 1'b1;
          state     <= after_retire;
        end
        ST_EX_ST0: state <= ST_EX_ST1;
        ST_EX_ST1: begin
          if (mem_done) begin
            instr_cnt <= instr_cnt + 1'b1;
            state     <= after_retire;
          end
        end
        ST_EX_JMP: begin
          instr_cnt <= instr_cnt + 1'b1;
          state     <= after_retire;
        end
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Strobe decode: one state drives at most one MAR source and one memory op
  always_comb begin
    c_pc_to_mar  = 1'b0;
    c_mbr_to_mar = 1'b0;
    c_mem_rd     = 1'b0;
    c_mem_wr     = 1'b0;
    c_pc_inc     = 1'b0;
    c_pc_load    = 1'b0;
    c_acc_to_mbr = 1'b0;
    c_acc_load   = 1'b0;
    c_alu_op     = ALU_PASS;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      ST_FETCH0: c_pc_to_mar = 1'b1;
      ST_FETCH1: begin
        c_mem_rd = 1'b1;
        // PC advances only once, in the cycle the read completes
        c_pc_inc = mem_done;
      end
      ST_FETCH2: c_mbr_to_mar = 1'b1;
      ST_DECODE: illegal_op = ~is_legal(op8);
      ST_EX_RD:  c_mem_rd = 1'b1;
      ST_EX_ALU: begin
        c_acc_load = 1'b1;
        c_alu_op   = alu_op_for(op8);
      end
      ST_EX_ST0: c_acc_to_mbr = 1'b1;
      ST_EX_ST1: c_mem_wr = 1'b1;
      ST_EX_JMP: c_pc_load = 1'b1;
      ST_HALT:   halted = 1'b1;
      default:   ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Purpose  : Directed, table-driven self-checking bench for cpu_ctrl_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_seq;
  import cpu_ctrl_pkg::*;

  // Strobe vector layout: {pc_to_mar, mbr_to_mar, mem_rd, mem_wr, pc_inc,
  //  pc_load, acc_to_mbr, acc_load, alu_op[2:0], halted, illegal_op}
  localparam logic [12:0] S_PCMAR  = 13'h1000;
  localparam logic [12:0] S_MBRMAR = 13'h0800;
  localparam logic [12:0] S_RD     = 13'h0400;
  localparam logic [12:0] S_WR     = 13'h0200;
  localparam logic [12:0] S_INC    = 13'h0100;
  localparam logic [12:0] S_PCLD   = 13'h0080;
  localparam logic [12:0] S_A2MBR  = 13'h0040;
  localparam logic [12:0] S_ACC    = 13'h0020;
  localparam logic [12:0] S_HALT   = 13'h0002;
  localparam logic [12:0] S_ILL    = 13'h0001;
  localparam logic [12:0] S_NONE   = 13'h0000;

  typedef struct packed {
    logic [7:0]        op;
    logic              neg;
    logic [3:0]        len;
    logic [5:0][12:0]  s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  mbr_opcode;
  logic        acc_neg;
  logic        mem_ready;
  logic        c_pc_to_mar, c_mbr_to_mar, c_mem_rd, c_mem_wr, c_pc_inc;
  logic        c_pc_load, c_acc_to_mbr, c_acc_load, halted, illegal_op;
  logic [2:0]  c_alu_op;
  logic [15:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.OPW(8), .CNTW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mbr_opcode   (mbr_opcode),
    .acc_neg      (acc_neg),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready    (mem_ready),
`endif
    .c_pc_to_mar  (c_pc_to_mar),
    .c_mbr_to_mar (c_mbr_to_mar),
    .c_mem_rd     (c_mem_rd),
    .c_mem_wr     (c_mem_wr),
    .c_pc_inc     (c_pc_inc),
    .c_pc_load    (c_pc_load),
    .c_acc_to_mbr (c_acc_to_mbr),
    .c_acc_load   (c_acc_load),
    .c_alu_op     (c_alu_op),
    .halted       (halted),
    .illegal_op   (illegal_op),
    .instr_cnt    (instr_cnt)
  );

  function automatic logic [12:0] strobes();
    return {c_pc_to_mar, c_mbr_to_mar, c_mem_rd, c_mem_wr, c_pc_inc,
            c_pc_load, c_acc_to_mbr, c_acc_load, c_alu_op, halted, illegal_op};
  endfunction

  function automatic logic [12:0] alu(input logic [2:0] op);
    return S_ACC | {8'd0, op, 2'b00};
  endfunction

  function automatic vec_t mk(input logic [7:0] op, input logic neg, input logic [3:0] len,
                              input logic [12:0] e3, input logic [12:0] e4, input logic [12:0] e5);
    vec_t v;
    v.op   = op;
    v.neg  = neg;
    v.len  = len;
    v.s[0] = S_PCMAR;
    v.s[1] = S_RD | S_INC;
    v.s[2] = S_MBRMAR;
    v.s[3] = e3;
    v.s[4] = e4;
    v.s[5] = e5;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit later; invariants checked every cycle
  task automatic tick();
    @(posedge clk);
    #1;
    chk("invariant_mar_mem", {30'd0, c_pc_to_mar & c_mbr_to_mar, c_mem_rd & c_mem_wr}, 32'd0);
  endtask

  vec_t vecs [0:10];
  int   exp_cnt;

  initial begin
    vecs[0]  = mk(OP_LOAD,   1'b0, 4'd6, S_NONE, S_RD,   alu(ALU_PASS));
    vecs[1]  = mk(OP_ADD,    1'b1, 4'd6, S_NONE, S_RD,   alu(ALU_ADD));
    vecs[2]  = mk(OP_SUB,    1'b0, 4'd6, S_NONE, S_RD,   alu(ALU_SUB));
    vecs[3]  = mk(OP_AND,    1'b0, 4'd6, S_NONE, S_RD,   alu(ALU_AND));
    vecs[4]  = mk(OP_OR,     1'b0, 4'd6, S_NONE, S_RD,   alu(ALU_OR));
    vecs[5]  = mk(OP_STORE,  1'b0, 4'd6, S_NONE, S_A2MBR, S_WR);
    vecs[6]  = mk(OP_JMP,    1'b1, 4'd5, S_NONE, S_PCLD, S_NONE);
    vecs[7]  = mk(OP_JMPGEZ, 1'b1, 4'd4, S_NONE, S_NONE, S_NONE);
    vecs[8]  = mk(OP_JMPGEZ, 1'b0, 4'd5, S_NONE, S_PCLD, S_NONE);
    vecs[9]  = mk(8'hFF,     1'b0, 4'd4, S_ILL,  S_NONE, S_NONE);
    vecs[10] = mk(8'h00,     1'b0, 4'd4, S_ILL,  S_NONE, S_NONE);

    rst = 1'b1; run = 1'b0; mbr_opcode = 8'h00; acc_neg = 1'b0; mem_ready = 1'b1;

    // Reset held two cycles with run low
    tick(); tick();
    chk("reset_strobes", {19'd0, strobes()}, 32'd0);
    chk("reset_cnt", {16'd0, instr_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_hold", {19'd0, strobes()}, 32'd0);
    end

    // Back-to-back instructions from the table with run held high
    run = 1'b1;
    exp_cnt = 0;
    tick();
    for (int v = 0; v < 11; v++) begin
      mbr_opcode = vecs[v].op;
      acc_neg    = vecs[v].neg;
      for (int c = 0; c < int'(vecs[v].len); c++) begin
        chk($sformatf("vec%0d_cyc%0d", v, c), {19'd0, strobes()}, {19'd0, vecs[v].s[c]});
        tick();
      end
      exp_cnt++;
      chk($sformatf("vec%0d_cnt", v), {16'd0, instr_cnt}, exp_cnt);
      chk($sformatf("vec%0d_next_fetch", v), {19'd0, strobes()}, {19'd0, S_PCMAR});
    end

    // run dropped mid-LOAD: instruction completes, then IDLE until run returns
    mbr_opcode = OP_LOAD;
    tick(); // FETCH1
    run = 1'b0;
    tick(); tick(); tick(); // FETCH2, DECODE, EX_RD
    chk("stop_ex_rd", {19'd0, strobes()}, {19'd0, S_RD});
    tick(); // EX_ALU
    chk("stop_ex_alu", {19'd0, strobes()}, {19'd0, alu(ALU_PASS)});
    tick(); tick();
    exp_cnt++;
    chk("stop_idle", {19'd0, strobes()}, 32'd0);
    chk("stop_cnt", {16'd0, instr_cnt}, exp_cnt);
    run = 1'b1;
    tick();
    chk("resume_fetch", {19'd0, strobes()}, {19'd0, S_PCMAR});

    // HALT: absorbing with run high, counted once
    mbr_opcode = OP_HALT;
    tick(); tick(); tick(); // FETCH1, FETCH2, DECODE
    chk("halt_decode", {19'd0, strobes()}, 32'd0);
    tick();
    exp_cnt++;
    chk("halt_entry_cnt", {16'd0, instr_cnt}, exp_cnt);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold", {19'd0, strobes()}, {19'd0, S_HALT});
      chk("halt_cnt_frozen", {16'd0, instr_cnt}, exp_cnt);
    end
    rst = 1'b1;
    tick();
    chk("halt_reset_strobes", {19'd0, strobes()}, 32'd0);
    chk("halt_reset_cnt", {16'd0, instr_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_fetch", {19'd0, strobes()}, {19'd0, S_PCMAR});

`ifdef CTRL_MEM_WAIT_EN
    // Fetch read stalls three cycles; PC increments once when ready
    begin
      int inc_seen;
      int rd_seen;
      inc_seen = 0;
      rd_seen  = 0;
      mbr_opcode = OP_LOAD;
      mem_ready  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("wait_rd_hold", {19'd0, strobes()}, {19'd0, S_RD});
        rd_seen  += int'(c_mem_rd);
        inc_seen += int'(c_pc_inc);
      end
      mem_ready = 1'b1;
      #1;
      chk("wait_rd_done", {19'd0, strobes()}, {19'd0, S_RD | S_INC});
      rd_seen  += int'(c_mem_rd);
      inc_seen += int'(c_pc_inc);
      chk("wait_rd_cycles", rd_seen, 32'd4);
      chk("wait_inc_once", inc_seen, 32'd1);
      tick();
      chk("wait_fetch2", {19'd0, strobes()}, {19'd0, S_MBRMAR});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
